conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
Phase sequencer for the convolution datapath. It takes the APB-issued start pulse and the latched layer configuration, then runs the datapath through four phases: feature load, bias load, per-output-channel weight load/compute, and result streaming. It sits between the conv APB register block and the conv datapath. Its conv_done pulse also feeds the cycle counter.

Parameters:
CH_W, 10, width of channel-count fields and output-channel counter
FLEN_W, 6, width of the feature-length field

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
conv_start  in  1  one-cycle start pulse from APB
conv_abort  in  1  one-cycle soft abort from APB
num_inch  in  CH_W  input channel count
num_outch  in  CH_W  output channel count
flen  in  FLEN_W  feature map side length
f_writedone  in  1  feature buffer fully written
b_writedone  in  1  bias buffer fully written
w_writedone  in  1  weights for current output channel written
comp_done  in  1  compute for current output channel finished
send_done  in  1  current output channel fully streamed out
f_load_en  out  1  route S_AXIS stream to feature buffer
b_load_en  out  1  route S_AXIS stream to bias buffer
w_load_en  out  1  route S_AXIS stream to weight buffer
comp_start  out  1  one-cycle compute start pulse
rdy_to_send  out  1  enable M_AXIS result streaming
cur_outch  out  CH_W  index of the output channel in progress
num_inch_q  out  CH_W  latched input channel count
flen_q  out  FLEN_W  latched feature length
busy  out  1  high in every state except IDLE
cfg_err  out  1  sticky flag: last start carried an invalid configuration
conv_done  out  1  one-cycle completion pulse

Behaviour:
- Reset state: IDLE.
- Reset value of every output and register: 0.
- rstn is asynchronous and active-low. Asserting it mid-operation returns the block to IDLE immediately with all outputs 0.
- All outputs are registered or decoded from the state register. No input reaches an output combinationally.
- States: IDLE, LOAD_F, LOAD_B, LOAD_W, COMP, SEND, DONE.
- Level outputs by state:
  - f_load_en = (state==LOAD_F)
  - b_load_en = (state==LOAD_B)
  - w_load_en = (state==LOAD_W)
  - rdy_to_send = (state==SEND)
  - conv_done = (state==DONE)
- IDLE, conv_start=1:
  - Latch num_inch, num_outch, flen. Clear cur_outch.
  - If any of the three fields is 0: set cfg_err=1 and go to DONE.
  - Otherwise: clear cfg_err and go to LOAD_F.
  - f_load_en rises exactly 1 cycle after the start pulse.
- LOAD_F: on f_writedone go to LOAD_B.
- LOAD_B: on b_writedone go to LOAD_W.
- LOAD_W: on w_writedone go to COMP. comp_start is high for exactly the first cycle of COMP.
- COMP: on comp_done go to SEND. comp_done is honoured in any COMP cycle, including the first.
- SEND: on send_done:
  - If cur_outch == num_outch_q-1: go to DONE.
  - Otherwise: cur_outch += 1 and go to LOAD_W.
- DONE: stays exactly 1 cycle, then goes to IDLE. conv_done is therefore a single-cycle pulse.
- Ignored inputs:
  - conv_start while busy is ignored. The latched configuration is not disturbed.
  - Any done input arriving outside its own state is ignored.
- conv_abort:
  - In any non-IDLE state, go to IDLE on the next edge.
  - No conv_done pulse. cur_outch and cfg_err are held.
  - Abort has priority over a simultaneous done input.
  - Abort in IDLE has no effect, even together with conv_start; the start is dropped.
- cur_outch counts 0 .. num_outch_q-1 and never wraps. With num_outch=1, SEND goes straight to DONE.
- Done-to-done latency: a done input seen at edge N puts the next phase's enable high in cycle N+1.
- conv_done is the stop signal for the clock counter. The cycle count runs from the start pulse to the conv_done pulse inclusive.

Test Plan:
- Nominal run: num_inch=3, num_outch=2, flen=8; pulse start, then f/b/w/comp/send dones, each 5 cycles after its phase enable → 2 comp_start pulses, cur_outch sequence 0,1, one conv_done, cfg_err=0, busy back to 0.
- Invalid config: num_outch=0, start → cycle+1 in DONE with conv_done=1 and cfg_err=1; cycle+2 IDLE; no load enable ever asserted.
- Start while busy: second conv_start in LOAD_B with num_outch=9 → ignored; run completes after 2 channels, num_inch_q and flen_q unchanged.
- Abort: conv_abort together with comp_done in COMP at cur_outch=1 → IDLE next cycle, no conv_done, rdy_to_send never asserted, cur_outch holds 1.
- Reset mid-run: drop rstn while rdy_to_send=1 → all outputs 0 immediately, without waiting for a clock edge; after release, a new start with num_outch=1 completes normally.
- Edge timing: comp_done in the same cycle as comp_start → SEND on the next cycle; a stray send_done in LOAD_W → ignored.

Source files
------------

// File: rtl/conv_seq_ctrl_if.sv
// Handshake and configuration bundle between the conv sequencer and its
// neighbours (APB register block on the control side, datapath on the other).
interface conv_seq_ctrl_if #(
  parameter int CH_W   = 10,
  parameter int FLEN_W = 6
);
  logic              conv_start;
  logic              conv_abort;
  logic [CH_W-1:0]   num_inch;
  logic [CH_W-1:0]   num_outch;
  logic [FLEN_W-1:0] flen;
  logic              f_writedone;
  logic              b_writedone;
  logic              w_writedone;
  logic              comp_done;
  logic              send_done;
  logic              f_load_en;
  logic              b_load_en;
  logic              w_load_en;
  logic              comp_start;
  logic              rdy_to_send;
  logic [CH_W-1:0]   cur_outch;
  logic [CH_W-1:0]   num_inch_q;
  logic [FLEN_W-1:0] flen_q;
  logic              busy;
  logic              cfg_err;
  logic              conv_done;

  modport master (
    input  conv_start, conv_abort, num_inch, num_outch, flen,
           f_writedone, b_writedone, w_writedone, comp_done, send_done,
    output f_load_en, b_load_en, w_load_en, comp_start, rdy_to_send,
           cur_outch, num_inch_q, flen_q, busy, cfg_err, conv_done
  );

  modport slave (
    output conv_start, conv_abort, num_inch, num_outch, flen,
           f_writedone, b_writedone, w_writedone, comp_done, send_done,
    input  f_load_en, b_load_en, w_load_en, comp_start, rdy_to_send,
           cur_outch, num_inch_q, flen_q, busy, cfg_err, conv_done
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Phase sequencer: feature load, bias load, per-output-channel weight load and
// compute, result streaming, then a one-cycle completion pulse.
module conv_seq_ctrl #(
  parameter int CH_W   = 10,
  parameter int FLEN_W = 6
) (
  input logic             clk,
  input logic             rstn,
  conv_seq_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_F, S_LOAD_B, S_LOAD_W, S_COMP, S_SEND, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CH_W-1:0]   r_num_inch_q;
  logic [CH_W-1:0]   r_num_outch_q;
  logic [CH_W-1:0]   r_cur_outch;
  logic [FLEN_W-1:0] r_flen_q;
  logic              r_cfg_err;
  logic              r_comp_start;
  logic              w_start_ok;
  logic              w_cfg_bad;
  logic              w_last_ch;

  // Abort in IDLE swallows a coincident start.
  assign w_start_ok = bus.conv_start && !bus.conv_abort;
  assign w_cfg_bad  = (bus.num_inch == '0) || (bus.num_outch == '0) || (bus.flen == '0);
  assign w_last_ch  = (r_cur_outch == r_num_outch_q - CH_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && bus.conv_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_start_ok)      w_next = w_cfg_bad ? S_DONE : S_LOAD_F;
        S_LOAD_F: if (bus.f_writedone) w_next = S_LOAD_B;
        S_LOAD_B: if (bus.b_writedone) w_next = S_LOAD_W;
        S_LOAD_W: if (bus.w_writedone) w_next = S_COMP;
        S_COMP:   if (bus.comp_done)   w_next = S_SEND;
        S_SEND:   if (bus.send_done)   w_next = w_last_ch ? S_DONE : S_LOAD_W;
        S_DONE:                        w_next = S_IDLE;
        default:                       w_next = S_IDLE;
      endcase
    end
  end

  // comp_start is registered off the LOAD_W->COMP transition so it marks
  // exactly the first COMP cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_num_inch_q  <= '0;
      r_num_outch_q <= '0;
      r_flen_q      <= '0;
      r_cur_outch   <= '0;
      r_cfg_err     <= 1'b0;
      r_comp_start  <= 1'b0;
    end else begin
      r_comp_start <= (r_state == S_LOAD_W) && bus.w_writedone && !bus.conv_abort;
      if (r_state == S_IDLE && w_start_ok) begin
        r_num_inch_q  <= bus.num_inch;
        r_num_outch_q <= bus.num_outch;
        r_flen_q      <= bus.flen;
        r_cur_outch   <= '0;
        r_cfg_err     <= w_cfg_bad;
      end else if (r_state == S_SEND && bus.send_done && !bus.conv_abort && !w_last_ch) begin
        r_cur_outch <= r_cur_outch + CH_W'(1);
      end
    end
  end

  assign bus.f_load_en   = (r_state == S_LOAD_F);
  assign bus.b_load_en   = (r_state == S_LOAD_B);
  assign bus.w_load_en   = (r_state == S_LOAD_W);
  assign bus.rdy_to_send = (r_state == S_SEND);
  assign bus.conv_done   = (r_state == S_DONE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.comp_start  = r_comp_start;
  assign bus.cur_outch   = r_cur_outch;
  assign bus.num_inch_q  = r_num_inch_q;
  assign bus.flen_q      = r_flen_q;
  assign bus.cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: directed scenarios plus randomised runs, checked
// against cycle-budget and event-count expectations derived from phase delays.
module tb_conv_seq_ctrl;
  localparam int CH_W   = 10;
  localparam int FLEN_W = 6;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  conv_seq_ctrl_if #(.CH_W(CH_W), .FLEN_W(FLEN_W)) bus ();
  conv_seq_ctrl #(.CH_W(CH_W), .FLEN_W(FLEN_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  int cyc, done_cyc, n_cstart, n_done, n_rts, n_loads;
  int rts_before, done_before;
  logic [CH_W-1:0] outch_seen[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock; observe outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.comp_start === 1'b1) begin
      n_cstart++;
      outch_seen.push_back(bus.cur_outch);
    end
    if (bus.conv_done === 1'b1) begin
      n_done++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (bus.rdy_to_send === 1'b1) n_rts++;
    if (bus.f_load_en === 1'b1 || bus.b_load_en === 1'b1 || bus.w_load_en === 1'b1) n_loads++;
  endtask

  // Phase ids: 0 feature, 1 bias, 2 weight, 3 compute, 4 send.
  function automatic logic en(input int which);
    case (which)
      0: return bus.f_load_en;
      1: return bus.b_load_en;
      2: return bus.w_load_en;
      3: return bus.busy && !bus.f_load_en && !bus.b_load_en && !bus.w_load_en
                && !bus.rdy_to_send && !bus.conv_done;
      default: return bus.rdy_to_send;
    endcase
  endfunction

  task automatic set_done(input int which, input logic v);
    case (which)
      0: bus.f_writedone = v;
      1: bus.b_writedone = v;
      2: bus.w_writedone = v;
      3: bus.comp_done   = v;
      default: bus.send_done = v;
    endcase
  endtask

  function automatic int pick(input int kfix);
    return (kfix >= 0) ? kfix : int'($urandom_range(0, 3));
  endfunction

  // Expect the phase to be active now, stay k cycles, then pulse its done.
  task automatic phase(input int which, input int k);
    chk($sformatf("enter_phase%0d", which), 32'(en(which)), 1);
    if (which == 3) chk("comp_start_first", 32'(bus.comp_start), 1);
    for (int i = 0; i < k; i++) begin
      step();
      chk($sformatf("hold_phase%0d", which), 32'(en(which)), 1);
      if (which == 3 && i == 0) chk("comp_start_once", 32'(bus.comp_start), 0);
    end
    set_done(which, 1'b1);
    step();
    set_done(which, 1'b0);
  endtask

  task automatic run_full(input int inch, input int outch, input int fl,
                          input int kfix, input bit glitch);
    int model;
    int k;
    bus.num_inch   = CH_W'(inch);
    bus.num_outch  = CH_W'(outch);
    bus.flen       = FLEN_W'(fl);
    bus.conv_start = 1'b1;
    cyc = 0; done_cyc = -1; n_cstart = 0; n_done = 0;
    outch_seen.delete();
    model = 2;  // start cycle plus the DONE cycle
    step();
    bus.conv_start = 1'b0;
    k = pick(kfix); model += k + 1; phase(0, k);
    k = pick(kfix);
    if (glitch) begin
      chk("b_entry", 32'(bus.b_load_en), 1);
      bus.conv_start = 1'b1;
      bus.num_inch   = 10'd7;
      bus.num_outch  = 10'd9;
      bus.flen       = 6'd33;
      step();
      bus.conv_start = 1'b0;
      model += 1;
    end
    model += k + 1; phase(1, k);
    for (int ch = 0; ch < outch; ch++) begin
      chk("w_cur_outch", 32'(bus.cur_outch), ch);
      chk("w_entry", 32'(bus.w_load_en), 1);
      if (glitch) begin
        bus.send_done = 1'b1;
        step();
        bus.send_done = 1'b0;
        model += 1;
      end
      k = pick(kfix); model += k + 1; phase(2, k);
      k = glitch ? 0 : pick(kfix); model += k + 1; phase(3, k);
      k = pick(kfix); model += k + 1; phase(4, k);
    end
    chk("done_pulse", 32'(bus.conv_done), 1);
    chk("done_cfg_err", 32'(bus.cfg_err), 0);
    chk("done_last_ch", 32'(bus.cur_outch), outch - 1);
    step();
    chk("done_single", 32'(bus.conv_done), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("cycles", done_cyc + 1, model);
    chk("n_comp_start", n_cstart, outch);
    chk("n_conv_done", n_done, 1);
    chk("n_outch_seen", outch_seen.size(), outch);
    foreach (outch_seen[i]) chk("outch_seq", 32'(outch_seen[i]), i);
    chk("num_inch_q", 32'(bus.num_inch_q), inch);
    chk("flen_q", 32'(bus.flen_q), fl);
  endtask

  initial begin
    bus.conv_start = 1'b0; bus.conv_abort = 1'b0;
    bus.num_inch = '0; bus.num_outch = '0; bus.flen = '0;
    bus.f_writedone = 1'b0; bus.b_writedone = 1'b0; bus.w_writedone = 1'b0;
    bus.comp_done = 1'b0; bus.send_done = 1'b0;
    cyc = 0; done_cyc = -1; n_cstart = 0; n_done = 0; n_rts = 0; n_loads = 0;

    // Reset state
    step(); step();
    chk("rst_flags", 32'({bus.f_load_en, bus.b_load_en, bus.w_load_en, bus.comp_start,
                          bus.rdy_to_send, bus.busy, bus.cfg_err, bus.conv_done, bus.cur_outch}), 0);
    chk("rst_cfgq", 32'({bus.num_inch_q, bus.flen_q}), 0);
    rstn = 1'b1;
    step();

    // Nominal run, every done 5 cycles after its phase enable
    run_full(3, 2, 8, 5, 1'b0);

    // Start while busy, stray send_done in LOAD_W, comp_done on comp_start cycle
    run_full(3, 2, 8, 2, 1'b1);

    // Invalid configuration
    bus.num_inch = 10'd4; bus.num_outch = 10'd0; bus.flen = 6'd8;
    bus.conv_start = 1'b1; n_loads = 0; n_done = 0;
    step();
    bus.conv_start = 1'b0;
    chk("inv_done", 32'(bus.conv_done), 1);
    chk("inv_err", 32'(bus.cfg_err), 1);
    chk("inv_busy", 32'(bus.busy), 1);
    step();
    chk("inv_idle", 32'(bus.busy), 0);
    chk("inv_done_off", 32'(bus.conv_done), 0);
    chk("inv_err_sticky", 32'(bus.cfg_err), 1);
    step(); step();
    chk("inv_no_load", n_loads, 0);
    chk("inv_one_done", n_done, 1);

    // Abort together with comp_done in COMP of channel 1
    bus.num_inch = 10'd3; bus.num_outch = 10'd2; bus.flen = 6'd8;
    bus.conv_start = 1'b1;
    step();
    bus.conv_start = 1'b0;
    phase(0, 1); phase(1, 1); phase(2, 1); phase(3, 1); phase(4, 1);
    chk("abort_ch1_w", 32'(bus.cur_outch), 1);
    phase(2, 1);
    rts_before = n_rts; done_before = n_done;
    bus.conv_abort = 1'b1; bus.comp_done = 1'b1;
    step();
    bus.conv_abort = 1'b0; bus.comp_done = 1'b0;
    chk("abort_idle", 32'(bus.busy), 0);
    chk("abort_no_done", 32'(bus.conv_done), 0);
    chk("abort_hold_ch", 32'(bus.cur_outch), 1);
    chk("abort_hold_err", 32'(bus.cfg_err), 0);
    step(); step(); step();
    chk("abort_no_send", n_rts, rts_before);
    chk("abort_no_done_cnt", n_done, done_before);

    // Abort in IDLE drops a coincident start
    bus.num_outch = 10'd3;
    bus.conv_start = 1'b1; bus.conv_abort = 1'b1;
    step();
    bus.conv_start = 1'b0; bus.conv_abort = 1'b0;
    chk("idle_abort_busy", 32'(bus.busy), 0);
    chk("idle_abort_fload", 32'(bus.f_load_en), 0);
    chk("idle_abort_ch", 32'(bus.cur_outch), 1);

    // Asynchronous reset while streaming
    bus.num_inch = 10'd6; bus.num_outch = 10'd1; bus.flen = 6'd12;
    bus.conv_start = 1'b1;
    step();
    bus.conv_start = 1'b0;
    phase(0, 1); phase(1, 1); phase(2, 1); phase(3, 1);
    chk("rst_in_send", 32'(bus.rdy_to_send), 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_flags", 32'({bus.f_load_en, bus.b_load_en, bus.w_load_en, bus.comp_start,
                                bus.rdy_to_send, bus.busy, bus.cfg_err, bus.conv_done, bus.cur_outch}), 0);
    chk("rst_async_cfgq", 32'({bus.num_inch_q, bus.flen_q}), 0);
    step();
    rstn = 1'b1;
    step();
    run_full(5, 1, 4, -1, 1'b0);

    // Randomised configurations and phase delays
    for (int r = 0; r < 3; r++)
      run_full(int'($urandom_range(1, 1023)), int'($urandom_range(1, 3)),
               int'($urandom_range(1, 63)), -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
